// File: rtl/eth_line_receiver_if.sv
// Link-side bundle of the line receiver: the dibit stream coming in from the
// ethernet front end and the frame-buffer write / status signals going out.
// master = stream source and frame-buffer side; slave = the receiver itself.
interface eth_line_receiver_if #(
   parameter int ADDR_WIDTH = 17
);
   logic                  axiiv;
   logic [1:0]            axiid;
   logic [ADDR_WIDTH-1:0] pixel_addr_out;
   logic [15:0]           pixel_out;
   logic                  pixel_valid_out;
   logic [9:0]            line_num_out;
   logic                  line_done_out;
   logic                  frame_done_out;
   logic                  error_out;

   modport master (
      output axiiv, axiid,
      input  pixel_addr_out, pixel_out, pixel_valid_out, line_num_out,
             line_done_out, frame_done_out, error_out
   );

   modport slave (
      input  axiiv, axiid,
      output pixel_addr_out, pixel_out, pixel_valid_out, line_num_out,
             line_done_out, frame_done_out, error_out
   );
endinterface

// File: rtl/eth_line_receiver.sv
// Camera line-packet receiver: turns the 2-bit valid/data stream into a
// 16-bit line header plus H_PIXELS 565 pixels, and issues one frame-buffer
// write per pixel. Malformed packets raise a one-cycle error pulse.
//
// state  | meaning
// IDLE   | waiting for axiiv to start a packet
// HEADER | collecting the 8 dibits of the line header
// DATA   | collecting pixels; after the last one, waiting for axiiv low
// DRAIN  | discarding the rest of a bad packet until axiiv low
module eth_line_receiver #(
   parameter int H_PIXELS   = 240,
   parameter int V_LINES    = 320,
   parameter int ADDR_WIDTH = 17
) (
   input logic               clk_in,
   input logic               rst_in_n,
   eth_line_receiver_if.slave lnk
);
   localparam int PCW = $clog2(H_PIXELS + 1);
   localparam logic [PCW-1:0] PIX_TOTAL  = PCW'(H_PIXELS);
   localparam logic [9:0]     LINE_LAST  = 10'(V_LINES - 1);
   localparam logic [15:0]    LINE_LIMIT = 16'(V_LINES);

   typedef enum logic [1:0] {IDLE, HEADER, DATA, DRAIN} state_t;

   state_t                state, state_d;
   logic [2:0]            dib_cnt, dib_cnt_d;
   logic [PCW-1:0]        pix_cnt, pix_cnt_d;
   logic [13:0]           shift, shift_d;
   logic [15:0]           shift_in;
   logic [ADDR_WIDTH-1:0] addr, addr_d;
   logic [ADDR_WIDTH-1:0] pix_addr, pix_addr_d;
   logic [15:0]           pix, pix_d;
   logic                  pix_vld, pix_vld_d;
   logic [9:0]            line, line_d;
   logic                  line_done, line_done_d;
   logic                  frame_done, frame_done_d;
   logic                  err, err_d;

   // the current dibit appended to the seven already held forms a full word
   assign shift_in = {shift, lnk.axiid};

   // next-state, datapath and strobe decode; all outputs are registered so
   // every strobe lands one cycle after the dibit that caused it
   always_comb begin
      state_d      = state;
      dib_cnt_d    = dib_cnt;
      pix_cnt_d    = pix_cnt;
      shift_d      = shift;
      addr_d       = addr;
      pix_addr_d   = pix_addr;
      pix_d        = pix;
      line_d       = line;
      pix_vld_d    = 1'b0;
      line_done_d  = 1'b0;
      frame_done_d = 1'b0;
      err_d        = 1'b0;
      case (state)
         IDLE: begin
            if (lnk.axiiv) begin
               shift_d   = {12'd0, lnk.axiid};
               dib_cnt_d = 3'd1;
               state_d   = HEADER;
            end
         end
         HEADER: begin
            if (!lnk.axiiv) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               shift_d   = shift_in[13:0];
               dib_cnt_d = dib_cnt + 3'd1;
               if (dib_cnt == 3'd7) begin
                  // a value below V_LINES also guarantees the top 6 bits are zero
                  if (shift_in < LINE_LIMIT) begin
                     line_d    = shift_in[9:0];
                     addr_d    = ADDR_WIDTH'(int'(shift_in[9:0]) * H_PIXELS);
                     pix_cnt_d = '0;
                     state_d   = DATA;
                  end else begin
                     err_d   = 1'b1;
                     state_d = DRAIN;
                  end
               end
            end
         end
         DATA: begin
            if (pix_cnt == PIX_TOTAL) begin
               if (lnk.axiiv) begin
                  err_d   = 1'b1;
                  state_d = DRAIN;
               end else begin
                  line_done_d  = 1'b1;
                  frame_done_d = (line == LINE_LAST);
                  state_d      = IDLE;
               end
            end else if (!lnk.axiiv) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               shift_d   = shift_in[13:0];
               dib_cnt_d = dib_cnt + 3'd1;
               if (dib_cnt == 3'd7) begin
                  pix_vld_d  = 1'b1;
                  pix_d      = shift_in;
                  pix_addr_d = addr;
                  addr_d     = addr + ADDR_WIDTH'(1);
                  pix_cnt_d  = pix_cnt + PCW'(1);
               end
            end
         end
         DRAIN: begin
            if (!lnk.axiiv) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // state and datapath registers, cleared asynchronously
   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         state      <= IDLE;
         dib_cnt    <= '0;
         pix_cnt    <= '0;
         shift      <= '0;
         addr       <= '0;
         pix_addr   <= '0;
         pix        <= '0;
         line       <= '0;
         pix_vld    <= 1'b0;
         line_done  <= 1'b0;
         frame_done <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_d;
         dib_cnt    <= dib_cnt_d;
         pix_cnt    <= pix_cnt_d;
         shift      <= shift_d;
         addr       <= addr_d;
         pix_addr   <= pix_addr_d;
         pix        <= pix_d;
         line       <= line_d;
         pix_vld    <= pix_vld_d;
         line_done  <= line_done_d;
         frame_done <= frame_done_d;
         err        <= err_d;
      end
   end

   assign lnk.pixel_addr_out  = pix_addr;
   assign lnk.pixel_out       = pix;
   assign lnk.pixel_valid_out = pix_vld;
   assign lnk.line_num_out    = line;
   assign lnk.line_done_out   = line_done;
   assign lnk.frame_done_out  = frame_done;
   assign lnk.error_out       = err;
endmodule

// File: tb/tb_eth_line_receiver.sv
// Directed and randomized packets against a packet-level reference model.
module tb_eth_line_receiver;
   localparam int H  = 240;
   localparam int V  = 320;
   localparam int AW = 17;

   logic clk_in   = 1'b0;
   logic rst_in_n = 1'b0;

   eth_line_receiver_if #(.ADDR_WIDTH(AW)) lnk ();

   eth_line_receiver #(.H_PIXELS(H), .V_LINES(V), .ADDR_WIDTH(AW)) dut (
      .clk_in  (clk_in),
      .rst_in_n(rst_in_n),
      .lnk     (lnk.slave)
   );

   always #10 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   // observation log
   int obs_addr[$];
   int obs_data[$];
   int obs_cyc[$];
   int obs_err = 0, obs_ld = 0, obs_fd = 0, obs_both = 0, ld_cyc = 0, fd_cyc = 0;

   always @(negedge clk_in) begin
      if (rst_in_n) begin
         if (lnk.pixel_valid_out) begin
            obs_addr.push_back(int'(lnk.pixel_addr_out));
            obs_data.push_back(int'(lnk.pixel_out));
            obs_cyc.push_back(cyc);
         end
         if (lnk.error_out) obs_err <= obs_err + 1;
         if (lnk.line_done_out) begin
            obs_ld <= obs_ld + 1;
            ld_cyc <= cyc;
         end
         if (lnk.frame_done_out) begin
            obs_fd <= obs_fd + 1;
            fd_cyc <= cyc;
         end
         if (lnk.pixel_valid_out && lnk.error_out) obs_both <= obs_both + 1;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // packet under test and reference-model expectations
   logic [1:0] pkt[$];
   int dcyc[$];
   int exp_addr[$], exp_data[$], exp_idx[$];
   int exp_err, exp_ld, exp_fd;
   int model_line = 0;
   int last_cyc   = 0;

   task automatic add_word(input int w);
      for (int j = 7; j >= 0; j--) pkt.push_back(2'(w >> (2 * j)));
   endtask

   // expected result of a whole packet computed from its dibit list
   task automatic model();
      int len, hdr, nd, np, w;
      exp_addr.delete(); exp_data.delete(); exp_idx.delete();
      exp_err = 0; exp_ld = 0; exp_fd = 0;
      len = pkt.size();
      if (len < 8) begin
         exp_err = (len > 0) ? 1 : 0;
      end else begin
         hdr = 0;
         for (int i = 0; i < 8; i++) hdr = hdr * 4 + int'(pkt[i]);
         if (hdr >= V) begin
            exp_err = 1;
         end else begin
            model_line = hdr;
            nd = len - 8;
            np = nd / 8;
            if (np > H) np = H;
            for (int k = 0; k < np; k++) begin
               w = 0;
               for (int j = 0; j < 8; j++) w = w * 4 + int'(pkt[8 + 8 * k + j]);
               exp_addr.push_back(hdr * H + k);
               exp_data.push_back(w);
               exp_idx.push_back(8 + 8 * k + 7);
            end
            if (nd == 8 * H) begin
               exp_ld = 1;
               exp_fd = (hdr == V - 1) ? 1 : 0;
            end else begin
               exp_err = 1;
            end
         end
      end
   endtask

   task automatic run_pkt(input string tag);
      int b_s, b_err, b_ld, b_fd, b_both, n_obs, k0;
      b_s = obs_addr.size(); b_err = obs_err; b_ld = obs_ld; b_fd = obs_fd; b_both = obs_both;
      model();
      dcyc.delete();
      foreach (pkt[i]) begin
         @(posedge clk_in); #1;
         lnk.axiiv = 1'b1;
         lnk.axiid = pkt[i];
         dcyc.push_back(cyc);
      end
      @(posedge clk_in); #1;
      lnk.axiiv = 1'b0;
      lnk.axiid = 2'b00;
      last_cyc  = cyc;
      repeat (4) @(posedge clk_in);
      @(negedge clk_in);
      n_obs = obs_addr.size() - b_s;
      chk({tag, ".n_strobes"}, n_obs, exp_addr.size());
      if (n_obs > 0 && exp_addr.size() > 0) begin
         k0 = (n_obs < exp_addr.size()) ? n_obs - 1 : exp_addr.size() - 1;
         for (int k = 0; k < k0; k++) begin
            if (obs_addr[b_s + k] !== exp_addr[k] || obs_data[b_s + k] !== exp_data[k] ||
                obs_cyc[b_s + k] !== dcyc[exp_idx[k]] + 1) begin
               k0 = k;
               break;
            end
         end
         chk({tag, ".strobe_addr"}, obs_addr[b_s + k0], exp_addr[k0]);
         chk({tag, ".strobe_data"}, obs_data[b_s + k0], exp_data[k0]);
         chk({tag, ".strobe_cycle"}, obs_cyc[b_s + k0], dcyc[exp_idx[k0]] + 1);
      end
      chk({tag, ".errors"}, obs_err - b_err, exp_err);
      chk({tag, ".line_done"}, obs_ld - b_ld, exp_ld);
      chk({tag, ".frame_done"}, obs_fd - b_fd, exp_fd);
      chk({tag, ".strobe_and_error"}, obs_both - b_both, 0);
      chk({tag, ".line_num"}, int'(lnk.line_num_out), model_line);
      if (exp_ld == 1) chk({tag, ".line_done_cycle"}, ld_cyc, last_cyc + 1);
      if (exp_fd == 1) chk({tag, ".frame_done_cycle"}, fd_cyc, last_cyc + 1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".addr"}, int'(lnk.pixel_addr_out), 0);
      chk({tag, ".pixel"}, int'(lnk.pixel_out), 0);
      chk({tag, ".valid"}, int'(lnk.pixel_valid_out), 0);
      chk({tag, ".line_num"}, int'(lnk.line_num_out), 0);
      chk({tag, ".line_done"}, int'(lnk.line_done_out), 0);
      chk({tag, ".frame_done"}, int'(lnk.frame_done_out), 0);
      chk({tag, ".error"}, int'(lnk.error_out), 0);
   endtask

   initial begin
      #(20 * 200000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int kind, ln, nd, pix50;
      lnk.axiiv = 1'b0;
      lnk.axiid = 2'b00;
      #5;
      chk_all_zero("reset");
      repeat (2) @(posedge clk_in);
      #1 rst_in_n = 1'b1;
      repeat (2) @(posedge clk_in);

      pkt.delete(); add_word(5);
      for (int i = 0; i < H; i++) add_word(16'hA5C3);
      run_pkt("line5");

      pkt.delete(); add_word(319);
      for (int i = 0; i < H; i++) add_word(i);
      run_pkt("line319");

      pkt.delete(); add_word(16'h0140);
      for (int i = 0; i < 8 * H; i++) pkt.push_back(2'($urandom));
      run_pkt("bad_line320");

      pkt.delete(); add_word(0);
      for (int i = 0; i < H; i++) add_word(int'($urandom_range(0, 65535)));
      run_pkt("line0");

      pkt.delete(); add_word(2);
      for (int i = 0; i < 100; i++) add_word(int'($urandom_range(0, 65535)));
      for (int i = 0; i < 3; i++) pkt.push_back(2'($urandom));
      run_pkt("line2_short");

      pkt.delete(); add_word(7);
      for (int i = 0; i < H; i++) add_word(int'($urandom_range(0, 65535)));
      pkt.push_back(2'($urandom));
      run_pkt("line7_long");

      // reset during pixel 50 of line 10, while the strobe of pixel 49 is up
      pkt.delete(); add_word(10);
      for (int i = 0; i < H; i++) add_word(int'($urandom_range(0, 65535)));
      pix50 = 8 + 50 * 8;
      for (int i = 0; i <= pix50; i++) begin
         @(posedge clk_in); #1;
         lnk.axiiv = 1'b1;
         lnk.axiid = pkt[i];
      end
      #1;
      chk("rst_mid.pre_valid", int'(lnk.pixel_valid_out), 1);
      chk("rst_mid.pre_addr", int'(lnk.pixel_addr_out), 10 * H + 49);
      chk("rst_mid.pre_line", int'(lnk.line_num_out), 10);
      rst_in_n = 1'b0;
      #1;
      chk_all_zero("rst_mid");
      lnk.axiiv = 1'b0;
      repeat (2) @(posedge clk_in);
      #1 rst_in_n = 1'b1;
      model_line = 0;

      pkt.delete(); add_word(11);
      for (int i = 0; i < H; i++) add_word(int'($urandom_range(0, 65535)));
      run_pkt("line11");

      for (int p = 0; p < 6; p++) begin
         kind = int'($urandom_range(0, 4));
         ln   = int'($urandom_range(0, V - 1));
         pkt.delete();
         case (kind)
            0: begin
               add_word(ln);
               for (int i = 0; i < H; i++) add_word(int'($urandom_range(0, 65535)));
            end
            1: begin
               add_word(ln);
               nd = int'($urandom_range(0, 8 * H - 1));
               for (int i = 0; i < nd; i++) pkt.push_back(2'($urandom));
            end
            2: begin
               add_word(ln);
               nd = 8 * H + int'($urandom_range(1, 8));
               for (int i = 0; i < nd; i++) pkt.push_back(2'($urandom));
            end
            3: begin
               add_word(int'($urandom_range(V, 65535)));
               nd = int'($urandom_range(0, 40));
               for (int i = 0; i < nd; i++) pkt.push_back(2'($urandom));
            end
            default: begin
               nd = int'($urandom_range(1, 7));
               for (int i = 0; i < nd; i++) pkt.push_back(2'($urandom));
            end
         endcase
         run_pkt($sformatf("rand%0d_kind%0d", p, kind));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
